// File: rtl/bus_dest_regs.sv
// Bus destination register file: six loadable/incrementable/clearable registers
// plus a single-entry memory write port driven by a two-state request FSM.
module bus_dest_regs #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_data,
  input  logic [2:0]       dest_sel,
  input  logic             ld,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] ar_q,
  output logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] dr_q,
  output logic [WIDTH-1:0] ac_q,
  output logic [WIDTH-1:0] ir_q,
  output logic [WIDTH-1:0] tr_q,
  output logic             mem_wr_req,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic             mem_wr_ack,
  output logic             busy,
  output logic             o_dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_latch;
  logic [WIDTH-1:0] r_mem_data;
  logic [WIDTH-1:0] r_regs [6];

  // Register file: index k holds destination code k+1 (AR, PC, DR, AC, IR, TR).
  always_ff @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (rst) begin
        r_regs[k] <= '0;
      end else if (dest_sel == 3'(k + 1)) begin
        if (ld) begin
          r_regs[k] <= bus_data;
        end else if (inc) begin
          r_regs[k] <= r_regs[k] + 1'b1;
        end else if (clr) begin
          r_regs[k] <= '0;
        end
      end
    end
  end

  // Handshake: mem_wr_req acts as valid and mem_wr_ack as ready; the write
  // completes on the first edge where both are high, and data is held until then.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dest_sel == 3'b000 && ld) begin
          w_state_nxt = S_REQ;
          w_latch     = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_wr_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_mem_data <= bus_data;
      end
    end
  end

  assign ar_q        = r_regs[0];
  assign pc_q        = r_regs[1];
  assign dr_q        = r_regs[2];
  assign ac_q        = r_regs[3];
  assign ir_q        = r_regs[4];
  assign tr_q        = r_regs[5];
  assign mem_wr_data = r_mem_data;
  assign mem_wr_req  = (r_state == S_REQ);
  assign busy        = (r_state == S_REQ);
  assign o_dbg_state = r_state;

endmodule
